// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small FIFO feeds a TICK-paced serial framer
// (start, data LSB first, optional parity, one or two stop bits).
`timescale 1ns/1ps
module uart_tx_buffered #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          TICK,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVF_ERR,
  output logic                          S_DATA,
  output logic                          BUSY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP_A,
    ST_STOP_B
  } state_t;

  // Buffer storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  full;
  logic                  have_word;
  logic                  push;
  logic                  pop;

  // Framer state
  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  parity_q, parity_d;
  logic                  s_data_q, s_data_d;
  logic                  frame_done;
  logic [DATA_WIDTH-1:0] head;

  // Flow control looks only at the registered level, so a same-cycle pop
  // never opens room for a push into a full buffer.
  assign full       = (level_q == LW'(FIFO_DEPTH));
  assign have_word  = (level_q != '0);
  assign push       = DATA_VALID & ~full;
  assign head       = mem_q[rd_ptr_q];

  assign DATA_READY = ~full;
  assign FIFO_LEVEL = level_q;
  assign OVF_ERR    = ovf_q;
  assign S_DATA     = s_data_q;
  assign BUSY       = (state_q != ST_IDLE);

  // Buffer pointer, level and overflow next-state
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    ovf_d    = ovf_q | (DATA_VALID & full);
  end

  // Framer next-state; a pop loads the word and freezes the frame config
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    parity_d   = parity_q;
    pop        = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (TICK && have_word) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (TICK) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (TICK) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP_A;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (TICK) state_d = ST_STOP_A;
      end
      ST_STOP_A: begin
        if (TICK) begin
          if (stop2_q) state_d = ST_STOP_B;
          else         frame_done = 1'b1;
        end
      end
      ST_STOP_B: begin
        if (TICK) frame_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Back-to-back frames: the last stop period chains straight into START.
    if (frame_done) begin
      if (have_word) begin
        pop     = 1'b1;
        state_d = ST_START;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (pop) begin
      shift_d  = head;
      par_en_d = PAR_EN;
      stop2_d  = STOP2;
      parity_d = (^head) ^ PAR_TYP;
    end
  end

  // Line level selected by the current state; registered one CLK later
  always_comb begin
    s_data_d = 1'b1;
    unique case (state_q)
      ST_START:  s_data_d = 1'b0;
      ST_DATA:   s_data_d = shift_q[0];
      ST_PARITY: s_data_d = parity_q;
      default:   s_data_d = 1'b1;
    endcase
  end

  // Buffer storage write
  always_ff @(posedge CLK) begin
    // NOTE: storage has no reset; emptiness is carried by level and pointers.
    if (push) mem_q[wr_ptr_q] <= P_DATA;
  end

  // Control and datapath registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      parity_q  <= 1'b0;
      s_data_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      parity_q  <= parity_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed testbench for uart_tx_buffered (DATA_WIDTH=8, FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  logic       CLK;
  logic       RST;
  logic       TICK;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic [2:0] FIFO_LEVEL;
  logic       OVF_ERR;
  logic       S_DATA;
  logic       BUSY;

  int n_asserts = 0;
  int n_fail    = 0;
  int tick_div  = 1;
  int tick_phase = 0;

  uart_tx_buffered #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .TICK       (TICK),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .FIFO_LEVEL (FIFO_LEVEL),
    .OVF_ERR    (OVF_ERR),
    .S_DATA     (S_DATA),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard time limit so the run can never hang
  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge CLK);
    #1;
    if (tick_div == 0) begin
      TICK = 1'b0;
    end else if (tick_div == 1) begin
      TICK = 1'b1;
    end else begin
      tick_phase = (tick_phase + 1) % tick_div;
      TICK = (tick_phase == 0);
    end
  endtask

  task automatic set_div(input int d);
    tick_div   = d;
    tick_phase = 0;
    TICK       = (d != 0);
  endtask

  task automatic push(input logic [7:0] w);
    P_DATA     = w;
    DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (BUSY !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check({tag, "_busy_rise"}, BUSY, 1'b1);
  endtask

  // Checks a frame bit by bit; exp[0] is the start bit. Each bit must hold
  // for div CLKs; BUSY must stay high throughout except possibly the very
  // last sample, which must equal busy_after. toggle_bit flips PAR_EN/STOP2
  // mid-frame to show the frame config is frozen.
  task automatic check_frame(input string tag, input logic [11:0] exp, input int len,
                             input int div, input logic busy_after, input int toggle_bit);
    wait_busy(tag);
    for (int b = 0; b < len; b++) begin
      for (int c = 0; c < div; c++) begin
        if (b == toggle_bit && c == div / 2) begin
          PAR_EN = ~PAR_EN;
          STOP2  = ~STOP2;
        end
        step();
        check($sformatf("%s_bit%0d_clk%0d", tag, b, c), S_DATA, exp[b]);
        if (b == len - 1 && c == div - 1)
          check($sformatf("%s_busy_end", tag), BUSY, busy_after);
        else
          check($sformatf("%s_busy_b%0d", tag, b), BUSY, 1'b1);
      end
    end
  endtask

  initial begin
    int n;
    RST        = 1'b0;
    TICK       = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;
    P_DATA     = '0;
    DATA_VALID = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_sdata", S_DATA, 1'b1);
    check("rst_busy",  BUSY, 1'b0);
    check("rst_level", FIFO_LEVEL, 3'd0);
    check("rst_ready", DATA_READY, 1'b1);
    check("rst_ovf",   OVF_ERR, 1'b0);
    RST = 1'b1;
    set_div(1);

    // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
    push(8'hA5);
    check("a5_level_after_push", FIFO_LEVEL, 3'd1);
    check("a5_not_popped_same_cycle", BUSY, 1'b0);
    check_frame("a5", 12'h34A, 10, 1, 1'b0, -1);
    step();
    check("a5_idle_line", S_DATA, 1'b1);

    // 0x03 with even then odd parity
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    push(8'h03);
    check_frame("p03_even", 12'h406, 11, 1, 1'b0, -1);
    PAR_TYP = 1'b1;
    push(8'h03);
    check_frame("p03_odd", 12'h606, 11, 1, 1'b0, -1);
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;

    // Two stop bits, back-to-back frames; second push coincides with a pop
    STOP2 = 1'b1;
    push(8'h00);
    push(8'hFF);
    check("b2b_level_push_pop", FIFO_LEVEL, 3'd1);
    check("b2b_busy_start", BUSY, 1'b1);
    check_frame("b2b_00", 12'h600, 11, 1, 1'b1, -1);
    check_frame("b2b_ff", 12'h7FE, 11, 1, 1'b0, -1);
    STOP2 = 1'b0;

    // Fill with TICK held low; fifth word is dropped and flags overflow
    set_div(0);
    DATA_VALID = 1'b1;
    P_DATA = 8'h11; step();
    P_DATA = 8'h22; step();
    P_DATA = 8'h33; step();
    P_DATA = 8'h44; step();
    check("full_ready",   DATA_READY, 1'b0);
    check("full_level",   FIFO_LEVEL, 3'd4);
    check("full_ovf_pre", OVF_ERR, 1'b0);
    P_DATA = 8'h55; step();
    DATA_VALID = 1'b0;
    check("ovf_set",     OVF_ERR, 1'b1);
    check("ovf_level",   FIFO_LEVEL, 3'd4);
    check("ovf_no_busy", BUSY, 1'b0);
    set_div(1);
    check_frame("fill_11", 12'h222, 10, 1, 1'b1, -1);
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("fill_remaining_busy_cycles", n, 30);
    check("fill_drained_level", FIFO_LEVEL, 3'd0);
    check("ovf_sticky", OVF_ERR, 1'b1);

    // TICK every 16 CLKs, config toggled mid-frame must not alter the frame
    set_div(16);
    push(8'h5A);
    check_frame("slow_5a", 12'h2B4, 10, 16, 1'b0, 3);
    PAR_EN = 1'b0;
    STOP2  = 1'b0;
    set_div(1);

    // Reset during data bit 3 with two words queued
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (3) step();
    check("midrst_level_pre", FIFO_LEVEL, 3'd2);
    check("midrst_busy_pre",  BUSY, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_sdata", S_DATA, 1'b1);
    check("midrst_busy",  BUSY, 1'b0);
    check("midrst_level", FIFO_LEVEL, 3'd0);
    check("midrst_ready", DATA_READY, 1'b1);
    check("midrst_ovf",   OVF_ERR, 1'b0);
    step();
    step();
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("postrst_idle_%0d", i), {FIFO_LEVEL, BUSY, S_DATA}, 5'b000_0_1);
    end

    // First edge after reset release accepts a push
    RST = 1'b0;
    #2;
    RST = 1'b1;
    push(8'hA5);
    check("postrst_first_push", FIFO_LEVEL, 3'd1);
    check_frame("postrst_a5", 12'h34A, 10, 1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame, legal range 5..16.
REQ-002 Parameter FIFO_DEPTH, default 4: input buffer entries, power of two, at least 2.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 TICK  input  1  bit-period enable; the FSM advances only on cycles with TICK=1.
REQ-006 PAR_EN  input  1  1 = parity bit inserted after data.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 STOP2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 P_DATA  input  DATA_WIDTH  word to transmit.
REQ-010 DATA_VALID  input  1  P_DATA valid this cycle.
REQ-011 DATA_READY  output  1  buffer can accept a word; equals NOT full.
REQ-012 FIFO_LEVEL  output  clog2(FIFO_DEPTH)+1  count of buffered words.
REQ-013 OVF_ERR  output  1  sticky: a DATA_VALID was presented while full.
REQ-014 S_DATA  output  1  serial line, registered, idle high.
REQ-015 BUSY  output  1  high whenever FSM is not IDLE.

Function
REQ-016 Push occurs on a cycle with DATA_VALID=1 and DATA_READY=1; word written at tail, level +1.
REQ-017 DATA_VALID=1 with DATA_READY=0 drops the word and sets OVF_ERR=1 next cycle; it stays 1 until reset.
REQ-018 DATA_READY derives from the registered level only; a pop in the same cycle as a full-condition push does not admit the push.
REQ-019 A word pushed into an empty buffer is poppable no earlier than the following cycle.
REQ-020 Simultaneous push and pop: level unchanged, both pointers advance, pointers wrap modulo FIFO_DEPTH.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP_A, STOP_B.
REQ-022 IDLE: if level>0 and TICK=1, pop the head into the shift register, latch PAR_EN/PAR_TYP/STOP2, go to START.
REQ-023 Latched configuration holds for the whole frame; input changes mid-frame take effect at the next frame.
REQ-024 Each non-IDLE state lasts exactly one TICK period; transition on the cycle TICK=1.
REQ-025 START drives 0; DATA drives the word LSB first for DATA_WIDTH periods using an internal bit counter.
REQ-026 DATA -> PARITY if the latched PAR_EN=1, else -> STOP_A.
REQ-027 PARITY bit = XOR of the word for even; its inverse for odd.
REQ-028 STOP_A and STOP_B drive 1; STOP_A -> STOP_B if latched STOP2=1.
REQ-029 Last stop state with TICK=1: if level>0, pop and go directly to START (no idle gap); else go to IDLE.
REQ-030 S_DATA is registered: it changes one CLK after the state transition that selects it.
REQ-031 Frame length in TICK periods = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.

Reset
REQ-032 RST low asynchronously forces: FSM IDLE, buffer empty, pointers 0, FIFO_LEVEL=0, DATA_READY=1, OVF_ERR=0, S_DATA=1, BUSY=0.
REQ-033 Reset mid-frame aborts the frame immediately and discards all buffered words; no partial frame resumes after release.
REQ-034 After RST deasserts, the first push is accepted on the first rising edge.

Verification
REQ-035 DW=8, TICK=1 always, PAR_EN=0, STOP2=0, push 0xA5 -> S_DATA 0,1,0,1,0,0,1,0,1,1; BUSY high for 10 cycles.
REQ-036 Push 0x03 with PAR_EN=1, PAR_TYP=0, then again with PAR_TYP=1 -> parity bits 0 then 1; 11-period frames.
REQ-037 STOP2=1, push 0x00 and 0xFF back-to-back -> two 11-period frames, START of the second follows STOP_B directly, BUSY never drops.
REQ-038 FIFO_DEPTH=4, hold TICK=0, push 5 words -> DATA_READY=0 after 4 pushes, FIFO_LEVEL=4, OVF_ERR=1; the 5th word is never transmitted.
REQ-039 TICK every 16th cycle, push 0x5A -> each bit held 16 CLKs; toggling PAR_EN mid-frame leaves the frame unchanged.
REQ-040 Assert RST during DATA bit 3 with 2 words queued -> S_DATA=1, BUSY=0, FIFO_LEVEL=0 within the same cycle; no output until a new push.
